fwd_hazard_unit: RTL
====================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard-detection unit for the EX stage of the MIPS pipeline.
- Per-operand forward-source select for rs and rt from NUM_SRC younger-to-older pipeline write-back sources.
- Load-use stall generation.
- Registered scoreboard for one outstanding multi-cycle (MUL/DIV) operation.
- Saturating stall-cycle performance counter.
- Sits beside the ID/EX register; its stall output freezes PC/IF/ID and injects a bubble into EX.

Parameters:
- NUM_SRC, 2, number of forwarding sources; index 0 = youngest (MEM), index NUM_SRC-1 = oldest (WB).
- AW, 5, register address width.
- LOAD_SRC, 1, first source index at which load data is available; a load at index < LOAD_SRC causes a stall.
- MC_LAT_W, 4, width of the multi-cycle latency field.
- CNT_W, 16, width of the stall performance counter.
- FSEL_W, $clog2(NUM_SRC+1), derived width of the forward-select fields.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, synchronous active-low reset.
- ex_valid, input, 1, EX holds a real instruction.
- ex_rs_rd, input, 1, instruction reads rs.
- ex_rt_rd, input, 1, instruction reads rt (independent enable).
- ex_rs, input, AW, rs address.
- ex_rt, input, AW, rt address.
- src_regwrite, input, NUM_SRC, source k writes a register.
- src_memread, input, NUM_SRC, source k is a load.
- src_wraddr, input, NUM_SRC*AW, destination of source k, packed with k at bits [k*AW +: AW].
- mc_issue, input, 1, multi-cycle op leaves EX this cycle.
- mc_wraddr, input, AW, its destination.
- mc_lat, input, MC_LAT_W, cycles until its result is committed.
- fwd_rs, output, FSEL_W, 0 = register file, k+1 = source k.
- fwd_rt, output, FSEL_W, same encoding as fwd_rs.
- stall, output, 1, freeze front end and bubble EX.
- stall_lu, output, 1, stall cause is load-use.
- stall_mc, output, 1, stall cause is scoreboard.
- mc_busy, output, 1, multi-cycle op outstanding.
- stall_cnt, output, CNT_W, saturating count of stall cycles.

Behaviour:
- Operand match for k:
  - Operand X is in {rs, rt}.
  - Match requires ex_valid, X_rd, ex_X != 0, src_regwrite[k], and src_wraddr[k] == ex_X.
- fwd_X (combinational):
  - Lowest matching k wins; fwd_X = k+1.
  - No match gives fwd_X = 0.
  - Register 0 never forwards.
- Load-use (combinational):
  - stall_lu = 1 if, for either operand, the winning match k has k < LOAD_SRC and src_memread[k].
  - A load at an older k >= LOAD_SRC forwards normally.
- Scoreboard (registered):
  - State: mc_busy, mc_dst[AW], mc_cnt[MC_LAT_W].
  - mc_issue with mc_lat != 0: set mc_busy = 1, mc_dst = mc_wraddr, mc_cnt = mc_lat.
  - mc_issue with mc_lat == 0: mc_busy stays 0.
  - While busy, mc_cnt decrements each cycle; when mc_cnt == 1, mc_busy clears on the next edge.
  - stall_mc = 1 when mc_busy and ex_valid and an enabled operand != 0 equals mc_dst.
  - stall_mc is also 1 when mc_busy and mc_issue are both high (structural hazard).
  - In the structural-hazard case the issue is ignored and the current op is unchanged.
  - Issue on the same edge as completion (mc_cnt == 1): the new op is accepted.
- Stall outputs:
  - stall = stall_lu | stall_mc.
  - Both causes may be high together.
  - Forwarding selects remain valid during a stall.
- Counter: stall_cnt increments on every cycle with stall = 1 and saturates at all-ones without wrapping.
- Reset: on the clk edge with rst_n = 0:
  - mc_busy = 0, mc_dst = 0, mc_cnt = 0, stall_cnt = 0.
  - A reset mid multi-cycle op discards that op.
  - Combinational outputs follow from the reset state: fwd_rs = fwd_rt = 0 and stall = 0 unless the inputs demand otherwise.
- Latency:
  - fwd_*, stall_lu and stall are combinational, with zero-cycle latency.
  - The scoreboard takes effect the cycle after mc_issue.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_AW.
  - FSEL encoding constants FWD_RF = 0 and FWD_SRC_BASE = 1.
  - Default NUM_SRC and LOAD_SRC.
- One sub-module, fwd_pick: priority match of one operand against all sources.
  - Returns select, hit index and load flag.
  - Instantiated twice, once for rs and once for rt.

Test Plan:
- NUM_SRC=2. ex_rs=3, ex_rt=3, src0 writes 3 (non-load), src1 writes 3 → fwd_rs=1, fwd_rt=1, stall=0.
- src0 load to $5, ex_rt=5, ex_rt_rd=1, ex_rs_rd=0 → fwd_rt=1, stall=1, stall_lu=1. Move the same load to src1 → fwd_rt=2, stall=0.
- ex_rs=0 with both sources writing $0 → fwd_rs=0, stall=0. Also check ex_valid=0 with all matches present → everything 0.
- mc_issue, mc_wraddr=8, mc_lat=3; EX reads $8 on the following cycles → stall_mc=1 for exactly 3 cycles, mc_busy falls after the 3rd, stall_cnt=3.
- mc_busy with mc_cnt=1 and a new mc_issue to $9 with lat 2 → accepted, with mc_busy continuous. Issue while mc_cnt=2 → stall_mc=1 and the op is ignored.
- Drive stall for 2^CNT_W+5 cycles → stall_cnt holds 0xFFFF. Then assert rst_n=0 for one edge mid multi-cycle op → mc_busy=0, stall_cnt=0 next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the EX-stage forwarding and hazard logic.
// Holds register width, forward-select encoding and default source layout.
package pipe_pkg;

  localparam int REG_AW = 5;

  // Forward-select encoding: 0 = register file, k+FWD_SRC_BASE = source k.
  localparam int FWD_RF       = 0;
  localparam int FWD_SRC_BASE = 1;

  localparam int DEF_NUM_SRC  = 2;
  localparam int DEF_LOAD_SRC = 1;

endpackage : pipe_pkg

// File: rtl/fwd_pick.sv
// Priority match of one EX operand against all write-back sources.
// The youngest (lowest-index) matching source wins; register 0 never matches.
module fwd_pick
  import pipe_pkg::*;
#(
  parameter int NUM_SRC = DEF_NUM_SRC,
  parameter int AW      = REG_AW,
  parameter int FSEL_W  = $clog2(NUM_SRC + 1),
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                  en,
  input  logic [AW-1:0]         addr,
  input  logic [NUM_SRC-1:0]    src_regwrite,
  input  logic [NUM_SRC-1:0]    src_memread,
  input  logic [NUM_SRC*AW-1:0] src_wraddr,
  output logic [FSEL_W-1:0]     sel,
  output logic                  hit,
  output logic [IDX_W-1:0]      hit_idx,
  output logic                  hit_load
);

  always_comb begin
    // NOTE: every output gets a default before the loop so no latch is inferred.
    sel      = FSEL_W'(FWD_RF);
    hit      = 1'b0;
    hit_idx  = '0;
    hit_load = 1'b0;
    // Walk oldest to youngest so the youngest match is the last one written.
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      if (en && (addr != '0) && src_regwrite[k] &&
          (src_wraddr[k*AW +: AW] == addr)) begin
        hit      = 1'b1;
        hit_idx  = IDX_W'(k);
        sel      = FSEL_W'(FWD_SRC_BASE + k);
        hit_load = src_memread[k];
      end
    end
  end

endmodule : fwd_pick

// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select, load-use stall, multi-cycle scoreboard and
// saturating stall-cycle counter for the MIPS pipeline.
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int NUM_SRC  = DEF_NUM_SRC,
  parameter int AW       = REG_AW,
  parameter int LOAD_SRC = DEF_LOAD_SRC,
  parameter int MC_LAT_W = 4,
  parameter int CNT_W    = 16,
  parameter int FSEL_W   = $clog2(NUM_SRC + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_rs_rd,
  input  logic                  ex_rt_rd,
  input  logic [AW-1:0]         ex_rs,
  input  logic [AW-1:0]         ex_rt,
  input  logic [NUM_SRC-1:0]    src_regwrite,
  input  logic [NUM_SRC-1:0]    src_memread,
  input  logic [NUM_SRC*AW-1:0] src_wraddr,
  input  logic                  mc_issue,
  input  logic [AW-1:0]         mc_wraddr,
  input  logic [MC_LAT_W-1:0]   mc_lat,
  output logic [FSEL_W-1:0]     fwd_rs,
  output logic [FSEL_W-1:0]     fwd_rt,
  output logic                  stall,
  output logic                  stall_lu,
  output logic                  stall_mc,
  output logic                  mc_busy,
  output logic [CNT_W-1:0]      stall_cnt
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef struct packed {
    logic                busy;
    logic [AW-1:0]       dst;
    logic [MC_LAT_W-1:0] cnt;
  } mc_sb_t;

  mc_sb_t sb_q;

  logic             rs_en, rt_en;
  logic             rs_hit, rt_hit;
  logic [IDX_W-1:0] rs_idx, rt_idx;
  logic             rs_load, rt_load;

  assign rs_en = ex_valid & ex_rs_rd;
  assign rt_en = ex_valid & ex_rt_rd;

  fwd_pick #(
    .NUM_SRC (NUM_SRC),
    .AW      (AW),
    .FSEL_W  (FSEL_W),
    .IDX_W   (IDX_W)
  ) u_pick_rs (
    .en           (rs_en),
    .addr         (ex_rs),
    .src_regwrite (src_regwrite),
    .src_memread  (src_memread),
    .src_wraddr   (src_wraddr),
    .sel          (fwd_rs),
    .hit          (rs_hit),
    .hit_idx      (rs_idx),
    .hit_load     (rs_load)
  );

  fwd_pick #(
    .NUM_SRC (NUM_SRC),
    .AW      (AW),
    .FSEL_W  (FSEL_W),
    .IDX_W   (IDX_W)
  ) u_pick_rt (
    .en           (rt_en),
    .addr         (ex_rt),
    .src_regwrite (src_regwrite),
    .src_memread  (src_memread),
    .src_wraddr   (src_wraddr),
    .sel          (fwd_rt),
    .hit          (rt_hit),
    .hit_idx      (rt_idx),
    .hit_load     (rt_load)
  );

  // Load data only exists from LOAD_SRC onward; a younger winning load must wait.
  logic lu_rs, lu_rt;
  assign lu_rs    = rs_hit & rs_load & (int'(rs_idx) < LOAD_SRC);
  assign lu_rt    = rt_hit & rt_load & (int'(rt_idx) < LOAD_SRC);
  assign stall_lu = lu_rs | lu_rt;

  // Scoreboard hazards: a reader of the pending destination, or a second issue
  // while the current op is not completing on this edge.
  logic mc_done, mc_hit_rs, mc_hit_rt, mc_struct, mc_accept;
  assign mc_done   = sb_q.busy & (sb_q.cnt == MC_LAT_W'(1));
  assign mc_hit_rs = rs_en & (ex_rs != '0) & (ex_rs == sb_q.dst);
  assign mc_hit_rt = rt_en & (ex_rt != '0) & (ex_rt == sb_q.dst);
  assign mc_struct = sb_q.busy & mc_issue & ~mc_done;
  assign stall_mc  = (sb_q.busy & (mc_hit_rs | mc_hit_rt)) | mc_struct;
  assign mc_accept = mc_issue & (mc_lat != '0) & (~sb_q.busy | mc_done);

  assign stall   = stall_lu | stall_mc;
  assign mc_busy = sb_q.busy;

  // NOTE: sequential state uses non-blocking assignments and a synchronous reset
  // checked first, so a reset mid-operation simply discards the pending op.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sb_q      <= '0;
      stall_cnt <= '0;
    end else begin
      if (mc_accept) begin
        sb_q.busy <= 1'b1;
        sb_q.dst  <= mc_wraddr;
        sb_q.cnt  <= mc_lat;
      end else if (mc_done) begin
        sb_q.busy <= 1'b0;
        sb_q.cnt  <= '0;
      end else if (sb_q.busy) begin
        sb_q.cnt  <= sb_q.cnt - MC_LAT_W'(1);
      end

      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

endmodule : fwd_hazard_unit
